serial_tx: RTL and testbench

Parallel-to-serial transmitter for the 8-bit shift-register datapath. It accepts a byte over a valid/ready handshake, frames it with one start bit and one stop bit, and drives it LSB-first on a single serial line. Each bit is held for a programmable number of clock cycles. It is the sending end of the serial link whose receiver shifts incoming bits in at bit 7 and right-shifts them toward bit 0.

---
 rtl/serial_tx_pkg.sv | 18 +
 rtl/serial_tx_if.sv | 11 +
 rtl/serial_tx_bit_timer.sv | 38 +++
 rtl/serial_tx.sv | 117 +++++++++++
 tb/tb_serial_tx.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial link: FSM state encoding and frame geometry.
// Used by both the transmitter and the receiver.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  // Bit-counter value reached while the last data bit is on the line
  localparam logic [2:0] LAST_DATA_IDX = 3'(DATA_BITS - 1);

endpackage

// File: rtl/serial_tx_if.sv
// Byte handshake and serial-line bundle between a byte producer and the transmitter.
interface serial_tx_if;
  logic [7:0] din;
  logic       valid;
  logic       ready;
  logic       sout;
  logic       busy;

  modport master (output din, output valid, input ready, input sout, input busy);
  modport slave  (input din, input valid, output ready, output sout, output busy);
endinterface

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts 0..DIV-1 while enabled and pulses tick on the terminal count.
module bit_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] TERM = 8'(DIV - 1);

  logic [7:0] cnt;

  // Cycle counter; clear wins over counting so a new bit always starts at 0
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (en) begin
      if (cnt == TERM) begin
        cnt <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end else begin
      cnt <= cnt;
    end
  end

  // With DIV=1 TERM is 0, so tick is high on every enabled cycle
  always_comb begin
    tick = en && (cnt == TERM);
  end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: frames a byte with start/stop bits and sends it LSB-first,
// each bit held for DIV clock cycles.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  serial_tx_if.slave  bus
);

  state_t     state;
  state_t     state_next;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       accept;
  logic       tick;

  // Handshake decode: ready is purely a function of the registered state
  always_comb begin
    accept = bus.valid && (state == IDLE);
  end

  bit_timer #(.DIV(DIV)) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (state != IDLE),
    .tick (tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; STOP always returns to IDLE so frames never chain directly
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (tick) begin
          state_next = DATA;
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        if (tick && (bit_cnt == LAST_DATA_IDX)) begin
          state_next = STOP;
        end else begin
          state_next = DATA;
        end
      end
      STOP: begin
        if (tick) begin
          state_next = IDLE;
        end else begin
          state_next = STOP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift register and bit counter; the counter saturates at the last data bit
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= 8'd0;
      bit_cnt <= 3'd0;
    end else if (accept) begin
      shreg   <= bus.din;
      bit_cnt <= 3'd0;
    end else if ((state == DATA) && tick) begin
      shreg <= {1'b0, shreg[7:1]};
      if (bit_cnt != LAST_DATA_IDX) begin
        bit_cnt <= bit_cnt + 3'd1;
      end else begin
        bit_cnt <= bit_cnt;
      end
    end else begin
      shreg   <= shreg;
      bit_cnt <= bit_cnt;
    end
  end

  // Output decode from registered state and shift register only
  always_comb begin
    bus.sout  = 1'b1;
    bus.ready = 1'b0;
    bus.busy  = 1'b1;
    case (state)
      IDLE: begin
        bus.sout  = 1'b1;
        bus.ready = 1'b1;
        bus.busy  = 1'b0;
      end
      START:   bus.sout = 1'b0;
      DATA:    bus.sout = shreg[0];
      STOP:    bus.sout = 1'b1;
      default: bus.sout = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: table-driven frames, directed corner cases,
// randomized bytes against a frame-level reference model, and a loopback receiver.
module tb_serial_tx;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_tx_if if4 ();
  serial_tx_if if1 ();

  serial_tx #(.DIV(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  serial_tx #(.DIV(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loopback receiver: shifts in at bit 7, right-shifts toward bit 0
  logic       rx_active;
  logic [3:0] rx_n;
  logic [7:0] rx_shift;
  logic [7:0] rx_data;
  logic       rx_tick;

  bit_timer #(.DIV(4)) u_rx_timer (
    .clk(clk), .rst(rst), .clr(!rx_active), .en(rx_active), .tick(rx_tick)
  );

  always @(posedge clk) begin
    if (rst) begin
      rx_active <= 1'b0;
      rx_n      <= 4'd0;
      rx_shift  <= 8'd0;
      rx_data   <= 8'd0;
    end else if (!rx_active) begin
      if (if4.sout == 1'b0) begin
        rx_active <= 1'b1;
        rx_n      <= 4'd0;
      end
    end else if (rx_tick) begin
      if (rx_n == 4'd8) begin
        rx_active <= 1'b0;
        if (if4.sout == 1'b1) rx_data <= rx_shift;
      end else begin
        rx_shift <= {if4.sout, rx_shift[7:1]};
        rx_n     <= rx_n + 4'd1;
      end
    end
  end

  typedef struct {
    logic [7:0] din;
    logic [9:0] frame;   // frame[i] is the i-th bit on the line
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: expected line level t cycles after acceptance, from frame rules
  function automatic logic ref_sout(input logic [7:0] d, input int t, input int div);
    int idx;
    idx = t / div;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    return 1'b1;
  endfunction

  task automatic chk_idle4(input string name);
    chk({name, ".sout"},  {7'd0, if4.sout},  8'd1);
    chk({name, ".ready"}, {7'd0, if4.ready}, 8'd1);
    chk({name, ".busy"},  {7'd0, if4.busy},  8'd0);
  endtask

  // Present a byte on the DIV=4 DUT; returns 1 cycle-phase after the acceptance edge
  task automatic accept4(input logic [7:0] d);
    chk("accept.ready_before", {7'd0, if4.ready}, 8'd1);
    if4.din   = d;
    if4.valid = 1'b1;
    @(posedge clk); #1;
    if4.valid = 1'b0;
    if4.din   = 8'($urandom);
  endtask

  // Check a full DIV=4 frame from cycle index 0; ends in cycle index 40 (idle)
  task automatic check_frame4(input logic [7:0] d, input string name);
    for (int t = 0; t < 40; t++) begin
      chk({name, ".sout"},  {7'd0, if4.sout},  {7'd0, ref_sout(d, t, 4)});
      chk({name, ".ready"}, {7'd0, if4.ready}, 8'd0);
      chk({name, ".busy"},  {7'd0, if4.busy},  8'd1);
      @(posedge clk); #1;
    end
    chk_idle4({name, ".end"});
  endtask

  initial begin
    logic [7:0] d;
    logic       exp_s;
    logic       exp_r;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    if4.din = 8'd0; if4.valid = 1'b0;
    if1.din = 8'd0; if1.valid = 1'b0;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h3C, 10'b1001111000};
    vecs[2] = '{8'h81, 10'b1100000010};
    vecs[3] = '{8'h00, 10'b1000000000};
    vecs[4] = '{8'hFF, 10'b1111111110};
    vecs[5] = '{8'h5A, 10'b1010110100};

    // Reset values
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk_idle4("reset");
      chk("reset.dut1_sout", {7'd0, if1.sout}, 8'd1);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk_idle4("idle");
    end

    // Pending valid on a reset edge must not be accepted
    if4.valid = 1'b1; if4.din = 8'h55; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; if4.valid = 1'b0;
    chk_idle4("rst_valid");

    // Table-driven frames, bits compared against hand-built frame constants
    for (int v = 0; v < 6; v++) begin
      accept4(vecs[v].din);
      for (int t = 0; t < 40; t++) begin
        chk("table.sout", {7'd0, if4.sout}, {7'd0, vecs[v].frame[t/4]});
        chk("table.busy", {7'd0, if4.busy}, 8'd1);
        @(posedge clk); #1;
      end
      chk_idle4("table.end");
      @(posedge clk); #1;
    end

    // Ignore while busy: FF held throughout, accepted only at the first ready cycle
    accept4(8'h3C);
    if4.din = 8'hFF; if4.valid = 1'b1;
    check_frame4(8'h3C, "busy_ign");
    @(posedge clk); #1;
    if4.valid = 1'b0;
    check_frame4(8'hFF, "busy_ff");

    // Reset mid-frame during data bit 3
    accept4(8'h00);
    for (int t = 0; t < 17; t++) begin
      chk("midrst.sout", {7'd0, if4.sout}, {7'd0, ref_sout(8'h00, t, 4)});
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int t = 0; t < 24; t++) begin
      chk_idle4("midrst.after");
      @(posedge clk); #1;
    end
    accept4(8'h81);
    check_frame4(8'h81, "midrst.next");

    // Loopback through the receiver
    @(posedge clk); #1;
    accept4(8'hC3);
    check_frame4(8'hC3, "loop");
    chk("loop.rx_data", rx_data, 8'hC3);

    // DIV=1 back-to-back with valid held high
    if1.din = 8'h01; if1.valid = 1'b1;
    @(posedge clk); #1;
    if1.din = 8'h80;
    for (int t = 0; t < 22; t++) begin
      if (t < 10) begin
        exp_s = ref_sout(8'h01, t, 1); exp_r = 1'b0;
      end else if (t == 10 || t == 21) begin
        exp_s = 1'b1; exp_r = 1'b1;
      end else begin
        exp_s = ref_sout(8'h80, t - 11, 1); exp_r = 1'b0;
      end
      chk("div1.sout",  {7'd0, if1.sout},  {7'd0, exp_s});
      chk("div1.ready", {7'd0, if1.ready}, {7'd0, exp_r});
      if (t == 11) if1.valid = 1'b0;
      if (t < 21) begin
        @(posedge clk); #1;
      end
    end

    // Randomized bytes with random idle gaps
    for (int n = 0; n < 10; n++) begin
      d = 8'($urandom);
      repeat ($urandom_range(0, 4)) begin
        @(posedge clk); #1;
      end
      accept4(d);
      check_frame4(d, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
